chip_test_sequencer: RTL and testbench
======================================

# chip_test_sequencer

Top-level controller for the chip checker. It launches one per-chip tester (such as the 74xx test modules) on request and owns that tester's Run/Done/RSLT/DISP_RSLT handshake. It also drives the socket pin-mux select so only the active tester reaches the socket, applies a timeout, and holds a latched pass/fail verdict for the display logic.

## Interface
Parameters:
- N_CHIPS, 8: number of attached chip testers.
- SEL_W, 3: width of the chip select; N_CHIPS <= 2^SEL_W.
- TIMEOUT, 1023: maximum WAIT cycles before the test is declared hung; must be >= 1.

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on rising Clk; 0 = reset.
- Start  in  1  level request from the debounced button; rising edge starts a test.
- Chip_Sel  in  SEL_W  index of the chip to test; sampled on the Start edge.
- Done_i  in  N_CHIPS  Done outputs of the testers, bit k = tester k.
- RSLT_i  in  N_CHIPS  RSLT outputs of the testers; 1 = pass.
- Run_o  out  N_CHIPS  one-hot Run pulse to the selected tester.
- Disp_o  out  N_CHIPS  one-hot DISP_RSLT pulse to the selected tester; releases it to Halted.
- Mux_Sel  out  SEL_W  socket pin-mux select; equals the latched chip index.
- Busy  out  1  high from LAUNCH through RELEASE.
- Pass  out  1  latched verdict: tester reported pass.
- Fail  out  1  latched verdict: tester reported fail, timed out, or the select was invalid.
- Timeout  out  1  latched: the failure was caused by the timeout.
- Bad_Sel  out  1  latched: Chip_Sel >= N_CHIPS at Start.

## Operation
States: IDLE, LAUNCH, WAIT, SETTLE, RELEASE, SHOW.

- IDLE
  - A rising edge on Start latches Chip_Sel into sel.
  - It also clears Pass, Fail, Timeout and Bad_Sel.
  - If sel >= N_CHIPS: set Fail and Bad_Sel, go to SHOW. No Run is issued.
  - Otherwise go to LAUNCH.
- LAUNCH: Run_o[sel] = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: count cycles.
  - If Done_i[sel] = 1, go to SETTLE.
  - Else if the count reaches TIMEOUT, set Fail and Timeout, go to RELEASE.
  - Done_i bits other than sel are ignored.
- SETTLE: one cycle that lets the tester's registered RSLT stabilise.
  - Then capture: Pass = RSLT_i[sel], Fail = ~RSLT_i[sel].
  - Go to RELEASE.
- RELEASE: Disp_o[sel] = 1 for exactly this cycle. Go to SHOW.
- SHOW
  - Verdict flags are held.
  - A new rising edge on Start behaves as in IDLE: it clears the flags and begins a new test.
  - There is no timeout in SHOW.

Rules that apply in every state:
- Start edge detect uses a registered copy of Start. Holding Start high yields exactly one test.
- A Start edge while Busy = 1 is ignored and is not queued.
- Mux_Sel = sel at all times. It keeps its value in SHOW so the last chip stays selected.
- Run_o and Disp_o are one-hot or all-zero; at most one bit is high in any cycle.
- Pass and Fail are never both 1.

## Timing
- Reset (Reset = 0 at an edge) puts the block in IDLE with every output 0: Run_o, Disp_o, Mux_Sel, Busy, Pass, Fail, Timeout, Bad_Sel. sel and the registered Start copy are also 0.
  - Reset mid-test aborts without a Disp_o pulse. The tester is expected to share the same reset.
- Cycle numbering, with edge 0 being the edge that samples the Start rise:
  - Cycle 1: LAUNCH, Run_o high, Busy high.
  - Cycle 2: WAIT begins.
- If Done_i[sel] is first high at edge d:
  - d+1: SETTLE.
  - d+2: RELEASE, Pass/Fail valid, Disp_o high.
  - d+3: SHOW, Busy low.
- Minimum Start-to-verdict latency is 4 cycles, when Done is already high at the first WAIT edge.
- Timeout counter: ceil(log2(TIMEOUT+1)) bits. It saturates and never wraps.
  - The timeout fires at the edge where the count equals TIMEOUT, i.e. TIMEOUT WAIT cycles after entry.
- Done and timeout arriving on the same edge: Done wins and no timeout is flagged.
- Bad select: the verdict is valid 1 cycle after the Start edge. Busy stays 0.

## Test plan
- Pass path: Reset low 2 cycles, then Chip_Sel = 2 with a Start rise. The stub tester raises Done 10 cycles after Run with RSLT = 1.
  - Required: Run_o = 8'h04 for one cycle, Disp_o = 8'h04 for one cycle, then Pass = 1, Fail = 0, Mux_Sel = 2.
- Fail path: Chip_Sel = 5 with RSLT = 0.
  - Required: Fail = 1, Pass = 0, Timeout = 0, Disp_o = 8'h20 pulse.
- Timeout: TIMEOUT = 16 and the tester never asserts Done.
  - Required: after 16 WAIT cycles, Fail = 1 and Timeout = 1, Disp_o pulse is still issued, then Busy falls.
- Bad select: N_CHIPS = 6 with Chip_Sel = 7.
  - Required: no Run_o pulse, Fail = 1 and Bad_Sel = 1 one cycle later, Busy remains 0.
- Start held high for 100 cycles, plus extra Start edges while Busy.
  - Required: exactly one Run_o pulse. A Start edge in SHOW clears the flags and launches a second test.
- Reset mid-WAIT.
  - Required: the next cycle has all outputs 0 and state IDLE. A new Start then runs normally.

Source files
------------

// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: launches one chip tester, owns its Run/Done/RSLT/DISP handshake,
// drives the socket mux select, applies a WAIT timeout and latches the pass/fail verdict.
module chip_test_sequencer #(
    parameter int N_CHIPS = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [SEL_W-1:0]   Chip_Sel,
    input  logic [N_CHIPS-1:0] Done_i,
    input  logic [N_CHIPS-1:0] RSLT_i,
    output logic [N_CHIPS-1:0] Run_o,
    output logic [N_CHIPS-1:0] Disp_o,
    output logic [SEL_W-1:0]   Mux_Sel,
    output logic               Busy,
    output logic               Pass,
    output logic               Fail,
    output logic               Timeout,
    output logic               Bad_Sel
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
    localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, WAIT = 3'd2, SETTLE = 3'd3,
                           RELEASE = 3'd4, SHOW = 3'd5;

    logic [2:0]         state;
    logic [SEL_W-1:0]   sel;
    logic               start_q;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic [N_CHIPS-1:0] hot;
    logic               rise, done_sel, rslt_sel, bad;

    // an out-of-range sel gives an all-zero mask, so nothing is ever driven for it
    assign hot      = N_CHIPS'(1) << sel;
    assign rise     = Start & ~start_q;
    assign done_sel = |(Done_i & hot);
    assign rslt_sel = |(RSLT_i & hot);
    assign bad      = 32'(Chip_Sel) >= 32'(N_CHIPS);
    assign cnt_n    = (cnt == TMAX) ? cnt : cnt + 1'b1;
    assign Run_o    = (state == LAUNCH) ? hot : '0;
    assign Disp_o   = (state == RELEASE) ? hot : '0;
    assign Busy     = (state >= LAUNCH) && (state <= RELEASE);
    assign Mux_Sel  = sel;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            sel     <= '0;
            start_q <= 1'b0;
            cnt     <= '0;
            Pass    <= 1'b0;
            Fail    <= 1'b0;
            Timeout <= 1'b0;
            Bad_Sel <= 1'b0;
        end else begin
            start_q <= Start;
            case (state)
                IDLE, SHOW: if (rise) begin
                    sel     <= Chip_Sel;
                    Pass    <= 1'b0;
                    Timeout <= 1'b0;
                    Fail    <= bad;
                    Bad_Sel <= bad;
                    state   <= bad ? SHOW : LAUNCH;
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt_n;
                    // Done takes priority over a timeout on the same edge
                    if (done_sel) state <= SETTLE;
                    else if (cnt_n == TMAX) begin
                        Fail    <= 1'b1;
                        Timeout <= 1'b1;
                        state   <= RELEASE;
                    end
                end
                SETTLE: begin
                    Pass  <= rslt_sel;
                    Fail  <= ~rslt_sel;
                    state <= RELEASE;
                end
                RELEASE: state <= SHOW;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb_chip_test_sequencer: directed tests of the chip test sequencer with a behavioural tester stub.
module tb_chip_test_sequencer;
    logic       Clk, Reset, Start;
    logic [2:0] Chip_Sel;
    logic [7:0] done, rslt, run, disp;
    logic [2:0] mux, b_mux;
    logic       busy, pass, fail, tmo, bsel;
    logic [5:0] b_run, b_disp;
    logic       b_busy, b_pass, b_fail, b_tmo, b_bsel;
    int n_cmp = 0, n_bad = 0;

    chip_test_sequencer #(.N_CHIPS(8), .SEL_W(3), .TIMEOUT(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Chip_Sel(Chip_Sel), .Done_i(done), .RSLT_i(rslt),
        .Run_o(run), .Disp_o(disp), .Mux_Sel(mux), .Busy(busy), .Pass(pass), .Fail(fail),
        .Timeout(tmo), .Bad_Sel(bsel));

    chip_test_sequencer #(.N_CHIPS(6), .SEL_W(3), .TIMEOUT(16)) u_bad (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Chip_Sel(Chip_Sel), .Done_i(done[5:0]), .RSLT_i(rslt[5:0]),
        .Run_o(b_run), .Disp_o(b_disp), .Mux_Sel(b_mux), .Busy(b_busy), .Pass(b_pass), .Fail(b_fail),
        .Timeout(b_tmo), .Bad_Sel(b_bsel));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic check_idle(input string name);
        n_cmp++; if (run !== 8'h0) begin n_bad++; $display("FAIL %s run_o got %h want 00", name, run); end
        n_cmp++; if (disp !== 8'h0) begin n_bad++; $display("FAIL %s disp_o got %h want 00", name, disp); end
        n_cmp++; if (mux !== 3'd0) begin n_bad++; $display("FAIL %s mux_sel got %0d want 0", name, mux); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s busy got %b want 0", name, busy); end
        n_cmp++; if ({pass, fail, tmo, bsel} !== 4'b0) begin n_bad++; $display("FAIL %s pass/fail/tmo/bad got %b want 0000", name, {pass, fail, tmo, bsel}); end
    endtask

    // one test on the 8-chip DUT; exp_k is the negedge index (0 = LAUNCH cycle) where Disp_o must pulse
    task automatic run_chip(input string name, input int sel, input logic r, input int delay,
                            input int exp_k, input logic exp_pass, input logic exp_tmo, input bit keep_start);
        logic [7:0] hot;
        int runs, disps;
        hot = 8'd1 << sel;
        runs = 0;
        disps = 0;
        step();
        Start = 1'b0;
        done = ~hot;
        rslt = r ? hot : ~hot;
        step();
        Chip_Sel = 3'(sel);
        Start = 1'b1;
        for (int k = 0; k <= exp_k + 1; k++) begin
            step();
            if (run != 8'h0) runs++;
            if (disp != 8'h0) disps++;
            if (k == 0) begin
                n_cmp++; if (run !== hot) begin n_bad++; $display("FAIL %s run_o got %h want %h", name, run, hot); end
                n_cmp++; if ({busy, pass, fail} !== 3'b100) begin n_bad++; $display("FAIL %s launch busy/pass/fail got %b want 100", name, {busy, pass, fail}); end
            end
            if (k == exp_k - 1) begin
                n_cmp++; if ({disp, tmo} !== 9'h0) begin n_bad++; $display("FAIL %s early disp/tmo got %h/%b want 00/0", name, disp, tmo); end
            end
            if (k == exp_k) begin
                n_cmp++; if (disp !== hot) begin n_bad++; $display("FAIL %s disp_o got %h want %h", name, disp, hot); end
                n_cmp++; if ({busy, pass, fail, tmo} !== {1'b1, exp_pass, ~exp_pass, exp_tmo}) begin
                    n_bad++; $display("FAIL %s verdict busy/pass/fail/tmo got %b want %b", name, {busy, pass, fail, tmo}, {1'b1, exp_pass, ~exp_pass, exp_tmo}); end
            end
            if (k == exp_k + 1) begin
                n_cmp++; if ({busy, disp, pass, fail, tmo, bsel} !== {1'b0, 8'h0, exp_pass, ~exp_pass, exp_tmo, 1'b0}) begin
                    n_bad++; $display("FAIL %s show busy/disp/pass/fail/tmo/bad got %b want %b", name, {busy, disp, pass, fail, tmo, bsel}, {1'b0, 8'h0, exp_pass, ~exp_pass, exp_tmo, 1'b0}); end
                n_cmp++; if (mux !== 3'(sel)) begin n_bad++; $display("FAIL %s mux_sel got %0d want %0d", name, mux, sel); end
            end
            if (!keep_start) Start = 1'b0;
            if (delay >= 0 && k >= delay) done[sel] = 1'b1;
        end
        n_cmp++; if (runs != 1 || disps != 1) begin n_bad++; $display("FAIL %s pulse counts run/disp got %0d/%0d want 1/1", name, runs, disps); end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Chip_Sel = 3'd0; done = 8'h0; rslt = 8'h0;
        repeat (2) step();
        check_idle("reset");
        n_cmp++; if ({b_busy, b_fail, b_bsel, b_run} !== 9'h0) begin n_bad++; $display("FAIL reset6 outputs got %b want 0", {b_busy, b_fail, b_bsel, b_run}); end
        Reset = 1'b1;
        step();
    endtask

    task automatic test_pass();        run_chip("pass", 2, 1'b1, 10, 12, 1'b1, 1'b0, 1'b0); endtask
    task automatic test_fail();        run_chip("fail", 5, 1'b0, 3, 5, 1'b0, 1'b0, 1'b0); endtask
    task automatic test_min_latency(); run_chip("min_lat", 1, 1'b1, 1, 3, 1'b1, 1'b0, 1'b0); endtask
    task automatic test_timeout();     run_chip("timeout", 6, 1'b1, -1, 17, 1'b0, 1'b1, 1'b0); endtask

    task automatic test_done_vs_timeout();
        run_chip("done_at_tmo", 0, 1'b1, 16, 18, 1'b1, 1'b0, 1'b0);
        run_chip("done_after_tmo", 4, 1'b1, 17, 17, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_hold_start();
        int runs;
        runs = 0;
        run_chip("hold", 3, 1'b1, 2, 4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step();
            if (run != 8'h0) runs++;
        end
        n_cmp++; if (runs != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL hold extra runs/busy got %0d/%b want 0/0", runs, busy); end
        Start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int runs, disps;
        runs = 0;
        disps = 0;
        step();
        Start = 1'b0; done = 8'h7f; rslt = 8'h80;
        step();
        Chip_Sel = 3'd7;
        Start = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            step();
            if (run != 8'h0) runs++;
            if (disp != 8'h0) disps++;
            if (k == 10) begin
                n_cmp++; if (disp !== 8'h80) begin n_bad++; $display("FAIL b2b disp_o got %h want 80", disp); end
            end
            Start = (k < 9) ? k[0] : 1'b0;
            Chip_Sel = 3'd1;
            if (k >= 8) done[7] = 1'b1;
        end
        n_cmp++; if (runs != 1 || disps != 1) begin n_bad++; $display("FAIL b2b pulse counts run/disp got %0d/%0d want 1/1", runs, disps); end
        n_cmp++; if ({mux, busy, pass, fail} !== {3'd7, 3'b010}) begin n_bad++; $display("FAIL b2b mux/busy/pass/fail got %b want 111010", {mux, busy, pass, fail}); end
        run_chip("show_restart", 2, 1'b0, 4, 6, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        step();
        Start = 1'b0; done = 8'hf7; rslt = 8'hff;
        step();
        Chip_Sel = 3'd3;
        Start = 1'b1;
        repeat (5) step();
        n_cmp++; if ({busy, mux} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL midwait busy/mux got %b want 1011", {busy, mux}); end
        Reset = 1'b0;
        Start = 1'b0;
        step();
        check_idle("midwait_reset");
        Reset = 1'b1;
        run_chip("after_reset", 3, 1'b1, 4, 6, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_bad_sel();
        int bruns;
        bruns = 0;
        Reset = 1'b0; Start = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Chip_Sel = 3'd7;
        Start = 1'b1;
        step();
        n_cmp++; if ({b_run, b_busy, b_pass, b_fail, b_tmo, b_bsel} !== {6'h0, 5'b00101}) begin
            n_bad++; $display("FAIL badsel7 run/busy/pass/fail/tmo/bad got %b want 00000000101", {b_run, b_busy, b_pass, b_fail, b_tmo, b_bsel}); end
        n_cmp++; if (b_mux !== 3'd7) begin n_bad++; $display("FAIL badsel7 mux_sel got %0d want 7", b_mux); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (b_run != 6'h0 || b_disp != 6'h0 || b_busy) bruns++;
        end
        n_cmp++; if (bruns != 0 || {b_fail, b_bsel} !== 2'b11) begin n_bad++; $display("FAIL badsel7 hold activity/fail/bad got %0d/%b want 0/11", bruns, {b_fail, b_bsel}); end
        Start = 1'b0;
        step();
        Chip_Sel = 3'd6;
        Start = 1'b1;
        step();
        n_cmp++; if ({b_run, b_busy, b_fail, b_bsel} !== {6'h0, 3'b011}) begin n_bad++; $display("FAIL badsel6 run/busy/fail/bad got %b want 000000011", {b_run, b_busy, b_fail, b_bsel}); end
        Start = 1'b0;
        step();
        Chip_Sel = 3'd5;
        Start = 1'b1;
        step();
        n_cmp++; if ({b_run, b_busy, b_fail, b_bsel} !== {6'h20, 3'b100}) begin n_bad++; $display("FAIL sel5 run/busy/fail/bad got %b want 100000100", {b_run, b_busy, b_fail, b_bsel}); end
        Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_min_latency();
        test_timeout();
        test_done_vs_timeout();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_wait();
        test_bad_sel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
